// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation sequencer.
//   - FSM state codes (3-bit localparams)
//   - SEL_ZERO mux code and the per-step operand-select schedule
//   - STEPS / STEP_W sizing for the step counter
package interp_pkg;

    localparam int STEPS  = 7;
    localparam int STEP_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRE_2E   = 3'd1;
    localparam logic [2:0] ST_PRE_5E   = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_WAIT_EST = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic [2:0] SEL_ZERO = 3'b111;

    // Operand-mux code for each schedule step:
    // E2, ~E2, reg_2E, 2E3, ~2E3, reg_5E, ~2E2
    function automatic logic [2:0] step_sel(input logic [STEP_W-1:0] step);
        logic [2:0] sel;
        case (step)
            3'd0:    sel = 3'b011;
            3'd1:    sel = 3'b000;
            3'd2:    sel = 3'b010;
            3'd3:    sel = 3'b110;
            3'd4:    sel = 3'b100;
            3'd5:    sel = 3'b101;
            3'd6:    sel = 3'b001;
            default: sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/interp_step_cnt.sv
// Step/group counter pair for the interpolation sequencer.
//   clk_i, rst_ni   : clock, async active-low reset
//   adv_i           : advance one step (wraps step, bumps group)
//   clr_i           : synchronous clear of both counters (wins over adv_i)
//   step_o, group_o : current step / group
//   last_step_o     : step is the final schedule step
//   last_group_o    : group is the final group of the run
module interp_step_cnt
    import interp_pkg::*;
#(
    parameter int N_GROUPS = 6,
    parameter int GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              adv_i,
    input  logic              clr_i,
    output logic [STEP_W-1:0] step_o,
    output logic [GRP_W-1:0]  group_o,
    output logic              last_step_o,
    output logic              last_group_o
);

    logic [STEP_W-1:0] step_q;
    logic [GRP_W-1:0]  group_q;

    assign last_step_o  = (step_q == STEP_W'(STEPS - 1));
    assign last_group_o = (group_q == GRP_W'(N_GROUPS - 1));
    assign step_o       = step_q;
    assign group_o      = group_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q  <= '0;
            group_q <= '0;
        end else if (clr_i) begin
            step_q  <= '0;
            group_q <= '0;
        end else if (adv_i) begin
            if (last_step_o) begin
                step_q <= '0;
                // The final group is never bumped; the FSM clears instead.
                if (!last_group_o) begin
                    group_q <= group_q + GRP_W'(1);
                end
            end else begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Sequencer for the channel-estimation interpolation datapath.
// Walks the operand mux through a 7-step schedule per pilot group, preloads
// reg_2E / reg_5E before each group, and emits a valid/ready write strobe
// with the output index for every interpolated estimate. All outputs are
// decoded from registered state and counters only.
//   clk_i, rst_ni  : clock, async active-low reset
//   start_i        : begin a run (IDLE only)
//   abort_i        : synchronous return to IDLE from any state
//   est_valid_i    : pilot estimates for the next group are present
//   out_ready_i    : downstream accepts the current estimate
//   add1_sel_o     : operand-mux select
//   ld_2e_o/ld_5e_o: scratch register capture enables
//   out_valid_o    : interpolated estimate valid
//   out_idx_o      : group*STEPS + step
//   busy_o, done_o : run in progress / end-of-run pulse
//
// state       | meaning
// ------------+---------------------------------------------
// IDLE        | waiting for start
// PRE_2E      | capture reg_2E
// PRE_5E      | capture reg_5E
// RUN         | schedule steps, one estimate per handshake
// WAIT_EST    | group finished, waiting for next estimates
// DONE        | one-cycle end-of-run pulse
module interp_seq_ctrl
    import interp_pkg::*;
#(
    parameter int N_GROUPS = 6,
    parameter int IDX_W    = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             est_valid_i,
    input  logic             out_ready_i,
    output logic [2:0]       add1_sel_o,
    output logic             ld_2e_o,
    output logic             ld_5e_o,
    output logic             out_valid_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int GRP_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    logic [2:0]        state_q, state_d;
    logic              cnt_adv, cnt_clr;
    logic [STEP_W-1:0] step;
    logic [GRP_W-1:0]  group;
    logic              last_step, last_group;

    interp_step_cnt #(
        .N_GROUPS (N_GROUPS),
        .GRP_W    (GRP_W)
    ) u_step_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .adv_i        (cnt_adv),
        .clr_i        (cnt_clr),
        .step_o       (step),
        .group_o      (group),
        .last_step_o  (last_step),
        .last_group_o (last_group)
    );

    always_comb begin
        state_d = state_q;
        cnt_adv = 1'b0;
        cnt_clr = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:     if (start_i) state_d = ST_PRE_2E;
                ST_PRE_2E:   state_d = ST_PRE_5E;
                ST_PRE_5E:   state_d = ST_RUN;
                ST_RUN: begin
                    // out_valid is constant high in RUN, so ready alone is the accept.
                    if (out_ready_i) begin
                        if (last_step && last_group) begin
                            state_d = ST_DONE;
                            cnt_clr = 1'b1;
                        end else begin
                            cnt_adv = 1'b1;
                            if (last_step) state_d = ST_WAIT_EST;
                        end
                    end
                end
                ST_WAIT_EST: if (est_valid_i) state_d = ST_PRE_2E;
                ST_DONE: begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign add1_sel_o  = (state_q == ST_RUN) ? step_sel(step) : SEL_ZERO;
    assign ld_2e_o     = (state_q == ST_PRE_2E);
    assign ld_5e_o     = (state_q == ST_PRE_5E);
    assign out_valid_o = (state_q == ST_RUN);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign out_idx_o   = IDX_W'(group) * IDX_W'(STEPS) + IDX_W'(step);

endmodule

// File: tb/tb_interp_seq_ctrl.sv
module tb_interp_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, est_valid, out_ready;
    logic [2:0] add1_sel;
    logic       ld_2e, ld_5e, out_valid, busy, done;
    logic [5:0] out_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interp_seq_ctrl #(.N_GROUPS(6), .IDX_W(6)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .est_valid_i (est_valid),
        .out_ready_i (out_ready),
        .add1_sel_o  (add1_sel),
        .ld_2e_o     (ld_2e),
        .ld_5e_o     (ld_5e),
        .out_valid_o (out_valid),
        .out_idx_o   (out_idx),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Reference model: position in the run as a flat estimate index 0..41,
    // plus how many preload cycles remain and whether we wait for estimates.
    int  sched [7] = '{3, 0, 2, 6, 4, 5, 1};
    bit  m_busy, m_done, m_wait;
    int  m_pre, m_idx;
    int  done_cnt;

    function automatic void m_reset();
        m_busy = 0; m_done = 0; m_wait = 0; m_pre = 0; m_idx = 0;
    endfunction

    function automatic bit m_running();
        return m_busy && (m_pre == 0) && !m_wait && !m_done;
    endfunction

    function automatic void m_step(bit s, bit a, bit e, bit r);
        if (a) begin
            m_reset();
        end else if (!m_busy) begin
            if (s) begin m_busy = 1; m_pre = 2; m_idx = 0; end
        end else if (m_done) begin
            m_reset();
        end else if (m_pre > 0) begin
            m_pre = m_pre - 1;
        end else if (m_wait) begin
            if (e) begin m_wait = 0; m_pre = 2; end
        end else if (r) begin
            if (m_idx == 6 * 7 - 1) begin
                m_done = 1; m_idx = 0;
            end else begin
                m_idx = m_idx + 1;
                if (m_idx % 7 == 0) m_wait = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit run;
        run = m_running();
        chk("add1_sel",  int'(add1_sel),  run ? sched[m_idx % 7] : 7);
        chk("out_valid", int'(out_valid), int'(run));
        chk("out_idx",   int'(out_idx),   m_idx);
        chk("ld_2e",     int'(ld_2e),     int'(m_busy && m_pre == 2));
        chk("ld_5e",     int'(ld_5e),     int'(m_busy && m_pre == 1));
        chk("busy",      int'(busy),      int'(m_busy));
        chk("done",      int'(done),      int'(m_done));
    endtask

    task automatic cyc(input bit s, input bit a, input bit e, input bit r);
        start = s; abort = a; est_valid = e; out_ready = r;
        @(posedge clk);
        m_step(s, a, e, r);
        #1;
        if (done === 1'b1) done_cnt++;
        check_all();
    endtask

    task automatic run_to_end(input string tag, input bit e, input bit r);
        for (int i = 0; i < 300 && m_busy; i++) cyc(0, 0, e, r);
        chk(tag, int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; est_valid = 0; out_ready = 0;
        done_cnt = 0;
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Full run, ready and est_valid high
        done_cnt = 0;
        cyc(1, 0, 1, 1);
        chk("k1_ld_2e", int'(ld_2e), 1);
        cyc(0, 0, 1, 1);
        chk("k2_ld_5e", int'(ld_5e), 1);
        cyc(0, 0, 1, 1);
        chk("k3_first_sel", int'(add1_sel), 3);
        run_to_end("full_run_end", 1, 1);
        chk("full_run_done_pulses", done_cnt, 1);

        // Stall at step 3 for 3 cycles
        cyc(1, 0, 1, 1);
        for (int i = 0; i < 50 && !(m_running() && m_idx == 3); i++) cyc(0, 0, 1, 1);
        chk("reach_idx3", int'(out_idx), 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        chk("stall_sel", int'(add1_sel), 6);
        cyc(1, 0, 1, 1);   // start while busy must be ignored
        run_to_end("stall_run_end", 1, 1);

        // est_valid low for 5 cycles after group 0
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 50 && !m_wait; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        chk("wait_sel", int'(add1_sel), 7);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("resume_idx7", int'(out_idx), 7);
        chk("resume_valid", int'(out_valid), 1);
        run_to_end("est_run_end", 1, 1);

        // Abort at idx 20
        done_cnt = 0;
        cyc(1, 0, 1, 1);
        for (int i = 0; i < 100 && !(m_running() && m_idx == 20); i++) cyc(0, 0, 1, 1);
        chk("reach_idx20", int'(out_idx), 20);
        cyc(0, 1, 1, 1);
        chk("abort_idle", int'(busy), 0);
        chk("abort_no_done", done_cnt, 0);
        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("restart_idx0", int'(out_idx), 0);
        // Async reset mid-RUN
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // start + abort together in IDLE
        cyc(1, 1, 1, 1);
        cyc(0, 0, 1, 1);
        chk("start_abort_idle", int'(busy), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 127) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
